// File: rtl/mem_fill_arbiter.sv
// Shares the single main-memory port between I-cache fills, D-cache fills and D-cache
// write-through stores. Define ARB_ROUND_ROBIN_EN for a round-robin I/D tie-break.
module mem_fill_arbiter #(
   parameter int BLOCK_WORDS = 8,
   localparam int CNT_W = $clog2(BLOCK_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req,
   input  logic [15:0]      i_addr,
   input  logic             d_req,
   input  logic [15:0]      d_addr,
   input  logic             d_wr_req,
   input  logic [15:0]      d_wr_addr,
   input  logic [15:0]      d_wr_data,
   output logic             mem_en,
   output logic             mem_wr,
   output logic [15:0]      mem_addr,
   output logic [15:0]      mem_wdata,
   input  logic [15:0]      mem_rdata,
   input  logic             mem_valid,
   output logic [15:0]      fill_data,
   output logic [CNT_W-1:0] fill_word,
   output logic             i_fill_we,
   output logic             d_fill_we,
   output logic             i_done,
   output logic             d_done,
   output logic             d_wr_done,
   output logic             busy
);

   typedef enum logic [2:0] {IDLE, FILL_I, FILL_D, WRITE, ACK} state_t;
   typedef enum logic [1:0] {SRC_I, SRC_D, SRC_WR} src_t;

   localparam logic [15:0]    BASE_MASK = ~16'(2 * BLOCK_WORDS - 1);
   localparam logic [CNT_W:0] FULL_CNT  = (CNT_W + 1)'(BLOCK_WORDS);
   localparam logic [CNT_W:0] LAST_RX   = (CNT_W + 1)'(BLOCK_WORDS - 1);
   localparam logic [CNT_W:0] CNT_ONE   = (CNT_W + 1)'(1);

   state_t         state_q, state_d;
   src_t           src_q, src_d;
   logic [CNT_W:0] iss_cnt_q, iss_cnt_d;
   logic [CNT_W:0] rx_cnt_q, rx_cnt_d;
   logic [15:0]    base_q, base_d;
   logic           grant_d_fill, grant_i_fill;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d_q, last_d_d;   // 1: the most recent fill grant went to D

   always_comb begin
      grant_d_fill = d_req && (!i_req || !last_d_q);
      grant_i_fill = i_req && !grant_d_fill;
   end
`else
   always_comb begin
      grant_d_fill = d_req;
      grant_i_fill = i_req && !d_req;
   end
`endif

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      iss_cnt_d = iss_cnt_q;
      rx_cnt_d  = rx_cnt_q;
      base_d    = base_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_d  = last_d_q;
`endif
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      fill_data = 16'h0000;
      fill_word = '0;
      i_fill_we = 1'b0;
      d_fill_we = 1'b0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      d_wr_done = 1'b0;
      busy      = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            iss_cnt_d = '0;
            rx_cnt_d  = '0;
            if (d_wr_req) begin
               state_d = WRITE;
               src_d   = SRC_WR;
            end else if (grant_d_fill) begin
               state_d = FILL_D;
               src_d   = SRC_D;
               base_d  = d_addr & BASE_MASK;
`ifdef ARB_ROUND_ROBIN_EN
               last_d_d = 1'b1;
`endif
            end else if (grant_i_fill) begin
               state_d = FILL_I;
               src_d   = SRC_I;
               base_d  = i_addr & BASE_MASK;
`ifdef ARB_ROUND_ROBIN_EN
               last_d_d = 1'b0;
`endif
            end
         end
         FILL_I, FILL_D: begin
            // Issue side and return side run independently; returns arrive in issue order.
            if (iss_cnt_q < FULL_CNT) begin
               mem_en    = 1'b1;
               mem_addr  = base_q + 16'({iss_cnt_q, 1'b0});
               iss_cnt_d = iss_cnt_q + CNT_ONE;
            end
            if (mem_valid) begin
               fill_data = mem_rdata;
               fill_word = rx_cnt_q[CNT_W-1:0];
               i_fill_we = (state_q == FILL_I);
               d_fill_we = (state_q == FILL_D);
               rx_cnt_d  = rx_cnt_q + CNT_ONE;
               if (rx_cnt_q == LAST_RX)
                  state_d = ACK;
            end
         end
         WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
            state_d   = ACK;
         end
         ACK: begin
            i_done    = (src_q == SRC_I);
            d_done    = (src_q == SRC_D);
            d_wr_done = (src_q == SRC_WR);
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are forced quiet while reset is held, whatever the registered state.
      if (rst) begin
         mem_en    = 1'b0;
         mem_wr    = 1'b0;
         mem_addr  = 16'h0000;
         mem_wdata = 16'h0000;
         fill_data = 16'h0000;
         fill_word = '0;
         i_fill_we = 1'b0;
         d_fill_we = 1'b0;
         i_done    = 1'b0;
         d_done    = 1'b0;
         d_wr_done = 1'b0;
         busy      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         src_q     <= SRC_I;
         iss_cnt_q <= '0;
         rx_cnt_q  <= '0;
         base_q    <= 16'h0000;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         iss_cnt_q <= iss_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         base_q    <= base_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q  <= last_d_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: reset/grant vector table, directed corner
// sequences and randomized traffic against a transaction-level arbitration model.
module tb_mem_fill_arbiter;
   localparam int BW = 8;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, d_req, d_wr_req;
   logic [15:0]   i_addr, d_addr, d_wr_addr, d_wr_data;
   logic          mem_en, mem_wr;
   logic [15:0]   mem_addr, mem_wdata, mem_rdata;
   logic          mem_valid;
   logic [15:0]   fill_data;
   logic [CW-1:0] fill_word;
   logic          i_fill_we, d_fill_we, i_done, d_done, d_wr_done, busy;

   mem_fill_arbiter #(.BLOCK_WORDS(BW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_addr(d_addr),
      .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .fill_data(fill_data), .fill_word(fill_word),
      .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
      .i_done(i_done), .d_done(d_done), .d_wr_done(d_wr_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Memory responder controls (written only by the main test process)
   int          resp_max_gap  = 0;
   bit          resp_idx_mode = 1'b0;
   logic [15:0] resp_base     = 16'hA000;
   int          flush_req     = 0;
   int          inject_req    = 0;

   // Requester model: pending flags and held request payloads
   bit          p_i, p_d, p_w;
   logic [15:0] a_i, a_d, a_w, w_data;
   int          m_last = 0;   // 0: last fill grant was I, 1: D

   function automatic logic [15:0] resp_fn(input logic [15:0] a);
      if (resp_idx_mode) return resp_base + 16'(a[CW:1]);
      return a ^ 16'hC3C3;
   endfunction

   function automatic logic [7:0] out_vec();
      return {mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done, d_wr_done, busy};
   endfunction

   // Reads are queued in issue order and returned with random gaps.
   initial begin : responder
      logic [15:0] rq[$];
      int gap_left;
      int flush_seen;
      int inject_seen;
      gap_left = 0; flush_seen = 0; inject_seen = 0;
      mem_valid = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(posedge clk); #2;
         mem_valid = 1'b0;
         mem_rdata = 16'($urandom);
         if (flush_seen != flush_req) begin
            rq.delete();
            flush_seen = flush_req;
            gap_left = 0;
         end
         if (inject_seen != inject_req) begin
            mem_valid = 1'b1;
            inject_seen++;
         end else if (gap_left > 0) begin
            gap_left--;
         end else if (rq.size() > 0) begin
            mem_valid = 1'b1;
            mem_rdata = resp_fn(rq.pop_front());
            gap_left  = int'($urandom_range(0, resp_max_gap));
         end
         @(negedge clk);
         if (mem_en === 1'b1 && mem_wr === 1'b0) rq.push_back(mem_addr);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_reqs();
      i_req = p_i; d_req = p_d; d_wr_req = p_w;
      i_addr = a_i; d_addr = a_d; d_wr_addr = a_w; d_wr_data = w_data;
   endtask

   task automatic maybe_raise(input int pct);
      if (!p_i && int'($urandom_range(0, 99)) < pct) begin p_i = 1'b1; a_i = 16'($urandom); end
      if (!p_d && int'($urandom_range(0, 99)) < pct) begin p_d = 1'b1; a_d = 16'($urandom); end
      if (!p_w && int'($urandom_range(0, 99)) < pct) begin
         p_w = 1'b1; a_w = 16'($urandom); w_data = 16'($urandom);
      end
      apply_reqs();
   endtask

   // Which pending requester the arbiter must pick: -1 none, 0 I, 1 D, 2 store.
   function automatic int pick();
      if (p_w) return 2;
`ifdef ARB_ROUND_ROBIN_EN
      if (p_d && p_i) return (m_last == 1) ? 0 : 1;
`endif
      if (p_d) return 1;
      if (p_i) return 0;
      return -1;
   endfunction

   // Entered in a settled IDLE cycle whose requests produce grant g; leaves in the
   // settled IDLE cycle after the served request has been dropped.
   task automatic do_txn(input int g, input int pct);
      logic [15:0] base;
      int issued, rx;
      bit fin;
      if (g == 2) begin
         tick(); maybe_raise(pct); settle();
         chk("wr_cycle", {mem_en, mem_wr, busy, d_wr_done}, 4'b1110);
         chk("wr_addr", mem_addr, a_w);
         chk("wr_data", mem_wdata, w_data);
         tick(); maybe_raise(pct); settle();
         chk("wr_ack", out_vec(), 8'b0000_0011);
         tick(); p_w = 1'b0; maybe_raise(pct); settle();
      end else begin
         base   = ((g == 1) ? a_d : a_i) & 16'hFFF0;
         m_last = g;
         issued = 0; rx = 0; fin = 1'b0;
         for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            tick(); maybe_raise(pct); settle();
            if (issued < BW) begin
               chk("issue", {mem_en, mem_wr, mem_addr}, {1'b1, 1'b0, base + 16'(2 * issued)});
               issued++;
            end else begin
               chk("issue_end", {31'd0, mem_en}, 32'd0);
            end
            if (mem_valid) begin
               chk("fill_we", {i_fill_we, d_fill_we}, (g == 1) ? 2'b01 : 2'b10);
               chk("fill_word", fill_word, rx);
               chk("fill_data", fill_data, resp_fn(base + 16'(2 * rx)));
               rx++;
               if (rx == BW) fin = 1'b1;
            end else begin
               chk("no_fill_we", {i_fill_we, d_fill_we}, 2'b00);
            end
            chk("no_early_done", {i_done, d_done, d_wr_done}, 3'b000);
         end
         if (!fin) chk("fill_timeout", rx, BW);
         tick(); maybe_raise(pct); settle();
         chk("fill_done", out_vec(), (g == 1) ? 8'b0000_0101 : 8'b0000_1001);
         tick();
         if (g == 1) p_d = 1'b0; else p_i = 1'b0;
         maybe_raise(pct); settle();
      end
      chk("back_idle", {busy, mem_en, i_done, d_done, d_wr_done}, 5'b00000);
   endtask

   task automatic run_sched(input int pct, input int max_txn);
      int g;
      for (int k = 0; k < max_txn; k++) begin
         g = pick();
         if (g < 0) begin
            if (pct == 0) break;
            tick(); maybe_raise(pct); settle();
            chk("idle_wait", out_vec(), 8'h00);
         end else begin
            do_txn(g, pct);
         end
      end
   endtask

   task automatic clear_model();
      p_i = 1'b0; p_d = 1'b0; p_w = 1'b0;
      m_last = 0;
      apply_reqs();
   endtask

   // Reset with a given request set and the first cycle the grant must produce.
   typedef struct {
      bit          w, d, i;
      bit          en, wr;
      logic [15:0] addr;
   } vec_t;

   vec_t vecs[7];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{w:0, d:0, i:1, en:1, wr:0, addr:16'h1230};
      vecs[1] = '{w:0, d:1, i:0, en:1, wr:0, addr:16'h5670};
      vecs[2] = '{w:0, d:1, i:1, en:1, wr:0, addr:16'h5670};
      vecs[3] = '{w:1, d:1, i:1, en:1, wr:1, addr:16'h0040};
      vecs[4] = '{w:1, d:0, i:0, en:1, wr:1, addr:16'h0040};
      vecs[5] = '{w:0, d:0, i:0, en:0, wr:0, addr:16'h0000};
      vecs[6] = '{w:1, d:0, i:1, en:1, wr:1, addr:16'h0040};

      // Reset held two cycles with every request high
      rst = 1'b1;
      p_i = 1'b1; p_d = 1'b1; p_w = 1'b1;
      a_i = 16'h1234; a_d = 16'h567A; a_w = 16'h0040; w_data = 16'hBEEF;
      apply_reqs();
      for (int k = 0; k < 2; k++) begin
         tick(); settle();
         chk("rst_outputs", {out_vec(), mem_addr}, 24'h0);
         chk("rst_fill_bus", {fill_data, 5'd0, fill_word}, 24'h0);
      end
      tick(); rst = 1'b0; settle();
      chk("post_rst_idle", out_vec(), 8'h00);
      // Store first, then the D fill, then the I fill
      run_sched(0, 10);

      // Grant decisions straight out of reset
      for (int v = 0; v < 7; v++) begin
         tick(); rst = 1'b1; clear_model(); flush_req++; settle();
         tick(); rst = 1'b0;
         p_w = vecs[v].w; p_d = vecs[v].d; p_i = vecs[v].i;
         a_i = 16'h1234; a_d = 16'h567A; a_w = 16'h0040; w_data = 16'hBEEF;
         apply_reqs(); settle();
         chk("vec_idle", {31'd0, busy}, 32'd0);
         tick(); settle();
         chk($sformatf("vec%0d_grant", v), {mem_en, mem_wr, mem_addr},
             {vecs[v].en, vecs[v].wr, vecs[v].addr});
      end
      tick(); rst = 1'b1; clear_model(); flush_req++; settle();
      tick(); rst = 1'b0; settle();

      // I fill from 0x1234, returned words 0xA000+k
      resp_idx_mode = 1'b1; resp_base = 16'hA000;
      tick(); p_i = 1'b1; a_i = 16'h1234; apply_reqs(); settle();
      run_sched(0, 4);
      resp_idx_mode = 1'b0;

      // Simultaneous I and D requests
      tick(); p_i = 1'b1; p_d = 1'b1; a_i = 16'h0F02; a_d = 16'h7718; apply_reqs(); settle();
      run_sched(0, 4);
      // A D fill, then a tie: round robin now favours I
      tick(); p_d = 1'b1; a_d = 16'h3330; apply_reqs(); settle();
      run_sched(0, 4);
      tick(); p_i = 1'b1; p_d = 1'b1; a_i = 16'h4444; a_d = 16'h8888; apply_reqs(); settle();
      run_sched(0, 4);

      // Store alongside a D fill request
      tick(); p_w = 1'b1; p_d = 1'b1; a_w = 16'h0040; w_data = 16'hBEEF; a_d = 16'h2468;
      apply_reqs(); settle();
      run_sched(0, 4);

      // Gapped returns
      resp_max_gap = 3;
      tick(); p_d = 1'b1; a_d = 16'hBEE6; apply_reqs(); settle();
      run_sched(0, 4);
      resp_max_gap = 0;

      // Reset after three returned words; late valids must not write the cache
      begin
         int got;
         got = 0;
         tick(); p_i = 1'b1; a_i = 16'h2222; apply_reqs(); settle();
         for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            tick(); settle();
            if (i_fill_we === 1'b1) got++;
         end
         chk("t5_three_words", got, 3);
         tick(); rst = 1'b1; p_i = 1'b0; apply_reqs(); flush_req++; settle();
         chk("t5_rst_cycle", out_vec(), 8'h00);
         tick(); rst = 1'b0; m_last = 0; inject_req += 2; settle();
         chk("t5_late_valid1", {mem_valid, out_vec()}, {1'b1, 8'h00});
         tick(); settle();
         chk("t5_late_valid2", {mem_valid, out_vec()}, {1'b1, 8'h00});
         tick(); settle();
         chk("t5_still_idle", out_vec(), 8'h00);
         tick(); p_i = 1'b1; apply_reqs(); settle();
         run_sched(0, 4);
      end

      // Random traffic with requests arriving mid-transaction
      resp_max_gap = 2;
      tick(); maybe_raise(40); settle();
      run_sched(15, 60);
      run_sched(0, 10);
      chk("random_drained", {29'd0, p_i, p_d, p_w}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
